// File: rtl/fifo_sync_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fifo_sync_param                                            |
// | Description : Parametrised single-clock show-ahead FIFO with fill count, |
// |               programmable almost-full/almost-empty thresholds, sticky   |
// |               overflow/underflow error flags and write-through when full.|
// |                                                                          |
// | Ports                                                                    |
// |   clock        in   rising-edge clock                                    |
// |   reset        in   asynchronous, active-high reset                      |
// |   wn           in   write request                                        |
// |   data_in      in   write data [DATA_W]                                  |
// |   rn           in   read request, pops the head entry                    |
// |   clr_err      in   synchronous clear of overflow/underflow              |
// |   data_out     out  head entry (show-ahead), 0 while empty               |
// |   full         out  count == DEPTH                                      |
// |   empty        out  count == 0                                          |
// |   almost_full  out  count >= AF_LEVEL                                   |
// |   almost_empty out  count <= AE_LEVEL                                   |
// |   count        out  occupancy 0..DEPTH [$clog2(DEPTH)+1]                |
// |   overflow     out  sticky: a write was rejected                       |
// |   underflow    out  sticky: a read was attempted while empty           |
// |                                                                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module fifo_sync_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wn,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     rn,
    input  logic                     clr_err,
    output logic [DATA_W-1:0]        data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    // Storage address width, and pointer width with one extra wrap bit.
    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;

    localparam logic [c_PTR_W-1:0] c_AF_LEVEL = c_PTR_W'(AF_LEVEL);
    localparam logic [c_PTR_W-1:0] c_AE_LEVEL = c_PTR_W'(AE_LEVEL);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W-1:0] r_count;
    logic               r_overflow;
    logic               r_underflow;

    logic [c_ADDR_W-1:0] w_waddr;
    logic [c_ADDR_W-1:0] w_raddr;
    logic                w_empty;
    logic                w_full;
    logic                w_rd_ok;
    logic                w_wr_ok;

    assign w_waddr = r_wptr[c_ADDR_W-1:0];
    assign w_raddr = r_rptr[c_ADDR_W-1:0];

    // Equal pointers mean empty; same slot but opposite lap means full.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (w_waddr == w_raddr) && (r_wptr[c_ADDR_W] != r_rptr[c_ADDR_W]);

    // A read only happens when there is something to pop. A write into a
    // full FIFO is still accepted when a read frees the head slot in the
    // same cycle; that slot is exactly the one the write pointer targets.
    assign w_rd_ok = rn && !w_empty;
    assign w_wr_ok = wn && (!w_full || rn);

    // Storage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[w_waddr] <= data_in;
        end
    end

    // Pointers roll over naturally modulo 2*DEPTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
        end
    end

    // Occupancy counter: moves only when exactly one side is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + c_PTR_ONE;
                2'b01:   r_count <= r_count - c_PTR_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; clearing wins over a simultaneous new error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr_err) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wn && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end
            if (rn && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Outputs: all flags come from registered state only.
    assign data_out     = w_empty ? '0 : r_mem[w_raddr];
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_AF_LEVEL);
    assign almost_empty = (r_count <= c_AE_LEVEL);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire
